// File: rtl/muller_c_seq.sv
// Synchronous four-phase exerciser for a single Muller C-element: drives the
// inputs, watches the synchronized output, and tallies transition/hold checks.
`timescale 1ns/1ps
module muller_c_seq #(
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] iter_i,
    input  logic [TMO_W-1:0] tmo_i,
    output logic [N_IN-1:0]  c_in_o,
    input  logic             c_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);
    localparam int K_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [2:0] {IDLE, W_HI, H_HI, W_LO, H_LO, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N_IN-1:0]        c_in_q, c_in_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       pass_q, pass_d;
    logic [CNT_W-1:0]       fail_q, fail_d;
    logic [CNT_W-1:0]       iter_q, iter_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [TMO_W-1:0]       t_q, t_d;
    logic [K_W-1:0]         k_q, k_d;
    logic                   bad_q, bad_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N_IN-1:0]        k_sel;
    logic                   y_s;
    logic                   pass_ev, fail_ev, clear;

    assign y_s = sync_q[SYNC_STAGES-1];

    // The mixed vectors are only entered from a W_ state, so k is stable there.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_sel
        assign k_sel[gi] = (k_q == K_W'(gi));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            c_in_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            iter_q  <= '0;
            tmo_q   <= '0;
            t_q     <= '0;
            k_q     <= '0;
            bad_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            c_in_q  <= c_in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            iter_q  <= iter_d;
            tmo_q   <= tmo_d;
            t_q     <= t_d;
            k_q     <= k_d;
            bad_q   <= bad_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], c_out_i};
        end
    end

    always_comb begin
        state_d = state_q;
        c_in_d  = c_in_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        iter_d  = iter_q;
        tmo_d   = tmo_q;
        k_d     = k_q;
        t_d     = t_q + 1'b1;
        bad_d   = bad_q;
        pass_ev = 1'b0;
        fail_ev = 1'b0;
        clear   = 1'b0;

        case (state_q)
            IDLE: begin
                t_d = '0;
                if (start_i) begin
                    iter_d  = iter_i;
                    tmo_d   = (tmo_i == '0) ? TMO_W'(1) : tmo_i;
                    clear   = 1'b1;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (iter_i == '0) ? DONE : W_HI;
                end
            end
            W_HI: begin
                if (y_s) begin
                    pass_ev = 1'b1;
                    state_d = H_HI;
                end else if (t_q == tmo_q) begin
                    fail_ev = 1'b1;
                    state_d = H_HI;
                end
            end
            H_HI: begin
                bad_d = bad_q | ~y_s;
                if (t_q == tmo_q - 1'b1) begin
                    fail_ev = bad_d;
                    pass_ev = ~bad_d;
                    state_d = W_LO;
                end
            end
            W_LO: begin
                if (!y_s) begin
                    pass_ev = 1'b1;
                    state_d = H_LO;
                end else if (t_q == tmo_q) begin
                    fail_ev = 1'b1;
                    state_d = H_LO;
                end
            end
            H_LO: begin
                bad_d = bad_q | y_s;
                if (t_q == tmo_q - 1'b1) begin
                    fail_ev = bad_d;
                    pass_ev = ~bad_d;
                    iter_d  = iter_q - 1'b1;
                    k_d     = (k_q == K_W'(N_IN - 1)) ? '0 : k_q + 1'b1;
                    state_d = (iter_q == CNT_W'(1)) ? DONE : W_HI;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entry actions: load the phase vector, restart timer and hold monitor.
        if (state_d != state_q) begin
            t_d   = '0;
            bad_d = 1'b0;
            case (state_d)
                W_HI:    c_in_d = '1;
                H_HI:    c_in_d = ~k_sel;
                W_LO:    c_in_d = '0;
                H_LO:    c_in_d = k_sel;
                default: c_in_d = '0;
            endcase
        end

        if (clear) begin
            pass_d = '0;
            fail_d = '0;
            err_d  = 1'b0;
        end
        if (pass_ev && (pass_q != '1)) pass_d = pass_q + 1'b1;
        if (fail_ev) begin
            err_d = 1'b1;
            if (fail_q != '1) fail_d = fail_q + 1'b1;
        end
    end

    assign c_in_o     = c_in_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
endmodule
